// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline execute stage: ALU codes, mul/div op codes, FSM states.
package pipe_pkg;

    localparam int unsigned XLEN = 32;

    // Low three bits of ealuc select the basic ALU ops; bit 3 is don't-care for these
    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b100;
    localparam logic [2:0] ALUC_AND = 3'b001;
    localparam logic [2:0] ALUC_OR  = 3'b101;
    localparam logic [2:0] ALUC_XOR = 3'b010;
    localparam logic [2:0] ALUC_LUI = 3'b110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [2:0] MDOP_NONE  = 3'd0;
    localparam logic [2:0] MDOP_MULT  = 3'd1;
    localparam logic [2:0] MDOP_MULTU = 3'd2;
    localparam logic [2:0] MDOP_DIV   = 3'd3;
    localparam logic [2:0] MDOP_DIVU  = 3'd4;
    localparam logic [2:0] MDOP_MFHI  = 3'd5;
    localparam logic [2:0] MDOP_MFLO  = 3'd6;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIX
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) || (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/pipe_muldiv.sv
// Iterative shift-add multiplier / restoring divider owning the architectural HI/LO registers.
module pipe_muldiv
    import pipe_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             busy,
    output logic [XLEN-1:0]  hi,
    output logic [XLEN-1:0]  lo
);

    localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    md_state_e          state, state_next;
    logic [CNT_W-1:0]   count, count_next;

    logic [2*XLEN-1:0]  acc;
    logic [XLEN-1:0]    opnd;
    logic [XLEN-1:0]    a_raw;
    logic               is_div, div0, neg_lo, neg_hi;

    logic               signed_op, div_op;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic [XLEN:0]      mul_sum, div_shift, div_diff;
    logic               div_ge;

    // FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= MD_IDLE;
            count <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            busy  <= (state_next != MD_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_next = MD_RUN;
                    count_next = '0;
                end
            end
            MD_RUN: begin
                if (count == CNT_W'(MD_CYCLES - 1)) state_next = MD_FIX;
                else                               count_next = count + CNT_W'(1);
            end
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Signed ops run on magnitudes; result signs are restored in FIX
    always_comb begin
        signed_op = (op == MDOP_MULT) || (op == MDOP_DIV);
        div_op    = (op == MDOP_DIV) || (op == MDOP_DIVU);
        mag_a     = (signed_op && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
        mag_b     = (signed_op && b[XLEN-1]) ? (~b + XLEN'(1)) : b;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift - {1'b0, opnd};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        acc    <= {{XLEN{1'b0}}, div_op ? mag_a : mag_b};
                        opnd   <= div_op ? mag_b : mag_a;
                        a_raw  <= a;
                        is_div <= div_op;
                        div0   <= div_op && (b == '0);
                        neg_lo <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_hi <= signed_op && div_op && a[XLEN-1];
                    end
                end
                MD_RUN: begin
                    if (is_div) begin
                        acc <= div_ge ? {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1}
                                      : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                    end
                end
                MD_FIX: begin
                    if (div0) begin
                        lo <= '1;
                        hi <= a_raw;
                    end else if (is_div) begin
                        lo <= neg_lo ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
                        hi <= neg_hi ? (~acc[2*XLEN-1:XLEN] + XLEN'(1)) : acc[2*XLEN-1:XLEN];
                    end else begin
                        {hi, lo} <= neg_lo ? (~acc + (2*XLEN)'(1)) : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipeexe_md.sv
// EX stage: combinational ALU/shifter/jal path, mul/div unit and the md interlock.
module pipeexe_md
    import pipe_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ewreg,
    input  logic [4:0]       ern0,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             ejal,
    input  logic [XLEN-1:0]  ea,
    input  logic [XLEN-1:0]  eb,
    input  logic [XLEN-1:0]  eimm,
    input  logic [XLEN-1:0]  esa,
    input  logic [XLEN-1:0]  epc4,
    input  logic [2:0]       emdop,
    output logic [XLEN-1:0]  ealu,
    output logic [4:0]       ern,
    output logic             ewreg_o,
    output logic             md_stall,
    output logic [XLEN-1:0]  hi,
    output logic [XLEN-1:0]  lo
);

    logic [XLEN-1:0] opa, opb, alu_res;
    logic            md_busy, md_start, md_instr;

    assign opa      = eshift  ? esa  : ea;
    assign opb      = ealuimm ? eimm : eb;
    assign md_instr = is_muldiv(emdop);
    assign md_stall = md_busy && (emdop != MDOP_NONE);
    assign md_start = md_instr && !md_stall;

    pipe_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
        .clock  (clock),
        .resetn (resetn),
        .start  (md_start),
        .op     (emdop),
        .a      (ea),
        .b      (eb),
        .busy   (md_busy),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        alu_res = '0;
        case (ealuc[2:0])
            ALUC_ADD: alu_res = opa + opb;
            ALUC_SUB: alu_res = opa - opb;
            ALUC_AND: alu_res = opa & opb;
            ALUC_OR:  alu_res = opa | opb;
            ALUC_XOR: alu_res = opa ^ opb;
            ALUC_LUI: alu_res = {opb[15:0], 16'h0000};
            default: begin
                case (ealuc)
                    ALUC_SLL: alu_res = opb << opa[4:0];
                    ALUC_SRL: alu_res = opb >> opa[4:0];
                    ALUC_SRA: alu_res = XLEN'($signed(opb) >>> opa[4:0]);
                    default:  alu_res = '0;
                endcase
            end
        endcase
    end

    // jal link value wins, then HI/LO moves, then the ALU
    always_comb begin
        ealu = alu_res;
        if (ejal)                    ealu = epc4 + XLEN'(4);
        else if (emdop == MDOP_MFHI) ealu = hi;
        else if (emdop == MDOP_MFLO) ealu = lo;
        ern     = ejal ? REG_RA : ern0;
        ewreg_o = ewreg && !md_stall && !md_instr;
    end

endmodule

// File: tb/tb_pipeexe_md.sv
// Self-checking bench for pipeexe_md: ALU vector table, random ALU and mul/div against a reference model.
module tb_pipeexe_md;
    import pipe_pkg::*;

    logic        clock, resetn;
    logic        ewreg, ealuimm, eshift, ejal;
    logic [4:0]  ern0;
    logic [3:0]  ealuc;
    logic [31:0] ea, eb, eimm, esa, epc4;
    logic [2:0]  emdop;
    logic [31:0] ealu, hi, lo;
    logic [4:0]  ern;
    logic        ewreg_o, md_stall;

    int n_checks = 0;
    int n_fail   = 0;

    pipeexe_md dut (
        .clock(clock), .resetn(resetn), .ewreg(ewreg), .ern0(ern0), .ealuc(ealuc),
        .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm),
        .esa(esa), .epc4(epc4), .emdop(emdop), .ealu(ealu), .ern(ern), .ewreg_o(ewreg_o),
        .md_stall(md_stall), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  c;
        logic        shift, imm_sel, jal, wreg;
        logic [31:0] a, b, imm, sa, pc4;
        logic [4:0]  rn0;
        logic [31:0] exp_alu;
        logic [4:0]  exp_rn;
        logic        exp_wreg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0011: return b << a[4:0];
            4'b0111: return b >> a[4:0];
            4'b1111: return 32'($signed(b) >>> a[4:0]);
            4'b1011: return 32'h0;
            default: ;
        endcase
        case (c[2:0])
            3'd0:    return a + b;
            3'd4:    return a - b;
            3'd1:    return a & b;
            3'd5:    return a | b;
            3'd2:    return a ^ b;
            3'd6:    return b * 32'h10000;
            default: return 32'h0;
        endcase
    endfunction

    // Returns {hi, lo}
    function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            MDOP_MULT:  return 64'(sa * sb);
            MDOP_MULTU: return ua * ub;
            MDOP_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            MDOP_DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'h0;
        endcase
    endfunction

    task automatic idle_inputs();
        ewreg = 1'b1; ern0 = 5'd2; ealuc = 4'b0000; ealuimm = 1'b0; eshift = 1'b0;
        ejal = 1'b0; ea = 32'h0; eb = 32'h0; eimm = 32'h0; esa = 32'h0; epc4 = 32'h0;
        emdop = MDOP_NONE;
    endtask

    // Issue a mul/div, follow it with an interlocked mflo, then mfhi
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int n;
        exp = md_ref(op, a, b);
        idle_inputs();
        emdop = op; ea = a; eb = b;
        #1;
        chk({tag, " start_stall"}, 32'(md_stall), 32'h0);
        chk({tag, " start_wreg"}, 32'(ewreg_o), 32'h0);
        step();
        emdop = MDOP_MFLO; ea = 32'h5A5A5A5A; eb = 32'h0;
        #1;
        n = 0;
        while (md_stall && n < 100) begin
            chk({tag, " stalled_wreg"}, 32'(ewreg_o), 32'h0);
            n++;
            step();
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'd33);
        chk({tag, " mflo"}, ealu, exp[31:0]);
        chk({tag, " mflo_wreg"}, 32'(ewreg_o), 32'h1);
        chk({tag, " hi"}, hi, exp[63:32]);
        chk({tag, " lo"}, lo, exp[31:0]);
        emdop = MDOP_MFHI;
        #1;
        chk({tag, " mfhi"}, ealu, exp[63:32]);
        step();
        emdop = MDOP_NONE;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        emdop = MDOP_MFHI;
        #1;
        chk("reset md_stall", 32'(md_stall), 32'h0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset mfhi", ealu, 32'h0);
        emdop = MDOP_NONE;

        //          c       sh  im  jal wr  a             b             imm         sa     pc4         rn0   exp_alu       rn    w
        vecs.push_back('{4'b0000, 0, 0, 0, 1, 32'd5,        32'd7,        32'h0,      32'd0, 32'h0,      5'd4, 32'd12,       5'd4, 1});
        vecs.push_back('{4'b1111, 1, 0, 0, 1, 32'h0,        32'hF0000000, 32'h0,      32'd4, 32'h0,      5'd6, 32'hFF000000, 5'd6, 1});
        vecs.push_back('{4'b0110, 0, 1, 0, 1, 32'h0,        32'h0,        32'h1234,   32'd0, 32'h0,      5'd7, 32'h12340000, 5'd7, 1});
        vecs.push_back('{4'b1110, 0, 1, 0, 0, 32'h0,        32'h0,        32'hABCD,   32'd0, 32'h0,      5'd7, 32'hABCD0000, 5'd7, 0});
        vecs.push_back('{4'b0000, 0, 0, 1, 1, 32'd9,        32'd9,        32'h0,      32'd0, 32'h100,    5'd3, 32'h104,      5'd31, 1});
        vecs.push_back('{4'b0100, 0, 0, 0, 1, 32'd5,        32'd7,        32'h0,      32'd0, 32'h0,      5'd8, 32'hFFFFFFFE, 5'd8, 1});
        vecs.push_back('{4'b0101, 0, 0, 0, 1, 32'hF0,       32'h0F,       32'h0,      32'd0, 32'h0,      5'd8, 32'hFF,       5'd8, 1});
        vecs.push_back('{4'b1001, 0, 0, 0, 1, 32'hFF,       32'h0F,       32'h0,      32'd0, 32'h0,      5'd8, 32'h0F,       5'd8, 1});
        vecs.push_back('{4'b0010, 0, 1, 0, 1, 32'hF0,       32'h0,        32'hFF,     32'd0, 32'h0,      5'd8, 32'h0F,       5'd8, 1});
        vecs.push_back('{4'b0011, 0, 0, 0, 1, 32'h24,       32'h1,        32'h0,      32'd0, 32'h0,      5'd9, 32'h10,       5'd9, 1});
        vecs.push_back('{4'b0111, 0, 0, 0, 1, 32'd4,        32'hF0000000, 32'h0,      32'd0, 32'h0,      5'd9, 32'h0F000000, 5'd9, 1});
        vecs.push_back('{4'b1011, 0, 0, 0, 1, 32'd4,        32'hF0000000, 32'h0,      32'd0, 32'h0,      5'd9, 32'h0,        5'd9, 1});
        vecs.push_back('{4'b1000, 0, 0, 0, 1, 32'hFFFFFFFF, 32'd2,        32'h0,      32'd0, 32'h0,      5'd1, 32'h1,        5'd1, 1});

        foreach (vecs[i]) begin
            ealuc = vecs[i].c; eshift = vecs[i].shift; ealuimm = vecs[i].imm_sel;
            ejal = vecs[i].jal; ewreg = vecs[i].wreg; ea = vecs[i].a; eb = vecs[i].b;
            eimm = vecs[i].imm; esa = vecs[i].sa; epc4 = vecs[i].pc4; ern0 = vecs[i].rn0;
            emdop = MDOP_NONE;
            #1;
            chk($sformatf("vec%0d ealu", i), ealu, vecs[i].exp_alu);
            chk($sformatf("vec%0d ern", i), 32'(ern), 32'(vecs[i].exp_rn));
            chk($sformatf("vec%0d ewreg_o", i), 32'(ewreg_o), 32'(vecs[i].exp_wreg));
            step();
        end

        for (int i = 0; i < 40; i++) begin
            idle_inputs();
            ealuc = 4'($urandom_range(0, 15));
            eshift = 1'($urandom_range(0, 1));
            ealuimm = 1'($urandom_range(0, 1));
            ea = $urandom(); eb = $urandom(); eimm = $urandom();
            esa = 32'($urandom_range(0, 31));
            #1;
            chk($sformatf("rand_alu%0d c=%0h", i, ealuc), ealu,
                alu_ref(ealuc, eshift ? esa : ea, ealuimm ? eimm : eb));
            step();
        end

        run_md(MDOP_MULT,  32'hFFFFFFFD, 32'd7,        "mult");
        run_md(MDOP_DIVU,  32'd100,      32'd7,        "divu");
        run_md(MDOP_DIV,   32'hFFFFFFF9, 32'd2,        "div_neg");
        run_md(MDOP_DIV,   32'h1234,     32'h0,        "div_zero");
        run_md(MDOP_DIVU,  32'hDEADBEEF, 32'h0,        "divu_zero");
        run_md(MDOP_DIV,   32'h80000000, 32'hFFFFFFFF, "div_ovf");
        run_md(MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        run_md(MDOP_MULT,  32'h80000000, 32'h80000000, "mult_min");

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom() >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_md(rop, ra, rb, $sformatf("rand_md%0d op%0d", i, rop));
        end

        // Reset mid-operation; unrelated instructions overlap without stalling
        idle_inputs();
        emdop = MDOP_MULT; ea = 32'd12345; eb = 32'd678;
        step();
        emdop = MDOP_NONE; ealuc = 4'b0000; ea = 32'd1; eb = 32'd2;
        #1;
        chk("overlap md_stall", 32'(md_stall), 32'h0);
        chk("overlap ewreg_o", 32'(ewreg_o), 32'h1);
        chk("overlap ealu", ealu, 32'd3);
        for (int i = 0; i < 10; i++) step();
        resetn = 1'b0;
        #1;
        chk("in-reset ealu", ealu, 32'd3);
        step();
        resetn = 1'b1;
        emdop = MDOP_MFHI;
        #1;
        chk("midreset md_stall", 32'(md_stall), 32'h0);
        chk("midreset hi", hi, 32'h0);
        chk("midreset lo", lo, 32'h0);
        chk("midreset mfhi", ealu, 32'h0);
        chk("midreset ewreg_o", 32'(ewreg_o), 32'h1);
        for (int i = 0; i < 40; i++) begin
            step();
            if (md_stall || hi != 0 || lo != 0) begin
                chk("post-reset idle", {md_stall, hi[30:0] | lo[30:0]}, 32'h0);
                break;
            end
        end
        chk("post-reset hi", hi, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
